// File: rtl/sha3_round_sequencer.sv
// -----------------------------------------------------------------------------
// sha3_round_sequencer
//
// Control FSM that drives a Keccak-f[1600] step pipeline through ROUNDS rounds
// per permutation. It holds no state datapath: it issues one sample strobe per
// round to the first step stage, waits for the last stage's completion strobe,
// and steers the feedback mux and the iota round-constant index.
//
// Parameters
//   ROUNDS   rounds per permutation (1..31)
//   TIMEOUT  watchdog limit in WAIT cycles (2..255), used only with the
//            SHA3_SEQ_WATCHDOG_EN macro defined
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   in_valid      sponge presents a state on the pipeline input
//   in_ready      sequencer idle, can accept a permutation
//   out_valid     permuted state held stable on the pipeline outputs
//   out_ready     sponge consumes the result
//   round_sample  one-cycle sample strobe to the first step stage
//   round_good    last step stage has registered the round result
//   feed_sel      0: external state into stage 1, 1: feedback from last stage
//   round_idx     current round number (iota constant index)
//   last_round    busy and round_idx == ROUNDS-1
//   busy          any state other than IDLE
//   err           watchdog fired (sticky); constant 0 without the watchdog
//
// Optional feature: define SHA3_SEQ_WATCHDOG_EN to build the WAIT watchdog.
// -----------------------------------------------------------------------------
module sha3_round_sequencer #(
  parameter int ROUNDS  = 24,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       round_sample,
  input  logic       round_good,
  output logic       feed_sel,
  output logic [4:0] round_idx,
  output logic       last_round,
  output logic       busy,
  output logic       err
);

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("sha3_round_sequencer: ROUNDS out of range 1..31");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sha3_round_sequencer: TIMEOUT out of range 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  state_t     state;
  logic [4:0] idx_q;

`ifdef SHA3_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
  logic       err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= 5'd0;
`ifdef SHA3_SEQ_WATCHDOG_EN
      wd_cnt <= 8'd0;
      err_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            idx_q <= 5'd0;
            state <= ISSUE;
`ifdef SHA3_SEQ_WATCHDOG_EN
            err_q <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SHA3_SEQ_WATCHDOG_EN
          wd_cnt <= 8'd0;
`endif
        end
        WAIT: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (round_good) begin
            if (idx_q == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx_q <= idx_q + 5'd1;
              state <= ISSUE;
            end
          end
`ifdef SHA3_SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LIMIT) begin
            err_q <= 1'b1;
            idx_q <= 5'd0;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            idx_q <= 5'd0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from the state register; feed_sel holds through WAIT
  // because round_idx does not change until the round completes.
  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign round_sample = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign feed_sel     = ((state == ISSUE) || (state == WAIT)) && (idx_q != 5'd0);
  assign round_idx    = idx_q;
  assign last_round   = busy && (idx_q == LAST_IDX);

`ifdef SHA3_SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha3_round_sequencer.sv
module tb_sha3_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: ROUNDS=24, step pipeline modelled with D=1.
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, round_sample, round_good, feed_sel;
  logic       last_round, busy, err;
  logic [4:0] round_idx;
  logic       good_en = 1'b1, good_force = 1'b0;
  logic [7:0] dl_a = 8'd0;

  // Short instance: ROUNDS=1, step pipeline modelled with D=3.
  logic       s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic       s_in_ready, s_out_valid, s_round_sample, s_round_good, s_feed_sel;
  logic       s_last_round, s_busy, s_err;
  logic [4:0] s_round_idx;
  logic [7:0] dl_b = 8'd0;

  // Behavioural step pipeline: a sample strobe returns as good D cycles later.
  always @(posedge clk) begin
    dl_a <= {dl_a[6:0], round_sample};
    dl_b <= {dl_b[6:0], s_round_sample};
  end
  assign round_good   = (dl_a[0] & good_en) | good_force;
  assign s_round_good = dl_b[2];

  sha3_round_sequencer #(.ROUNDS(24), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .round_sample(round_sample),
    .round_good(round_good), .feed_sel(feed_sel), .round_idx(round_idx),
    .last_round(last_round), .busy(busy), .err(err)
  );

  sha3_round_sequencer #(.ROUNDS(1), .TIMEOUT(8)) u_short (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .round_sample(s_round_sample),
    .round_good(s_round_good), .feed_sel(s_feed_sel), .round_idx(s_round_idx),
    .last_round(s_last_round), .busy(s_busy), .err(s_err)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Finish the current permutation on the main instance and hand it off.
  task automatic drain_main(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    nchk++;
    if (out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL %s_drain: out_valid got %0b expected 1 (timeout)", tag, out_valid);
    end
    repeat ($urandom_range(0, 3)) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s_handoff: in_ready got %0b expected 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    nchk++;
    if ({in_ready, out_valid, round_sample, feed_sel, last_round, busy, err} !== 7'b1000000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b expected 1000000",
               {in_ready, out_valid, round_sample, feed_sel, last_round, busy, err});
    end
    nchk++;
    if (round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL reset_idx: got %0d expected 0", round_idx);
    end
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    nchk++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: in_ready %0b busy %0b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_nominal();
    int smp_cyc[$];
    int smp_idx[$];
    logic smp_fs[$];
    int first_ov = -1;
    logic fs2 = 1'bx, fs4 = 1'bx, lr45 = 1'bx, lr47 = 1'bx;
    in_valid = 1'b1;
    cyc = 0;
    tick();
    in_valid = 1'b0;
    while (cyc <= 60) begin
      if (round_sample) begin
        smp_cyc.push_back(cyc);
        smp_idx.push_back(int'(round_idx));
        smp_fs.push_back(feed_sel);
      end
      if (cyc == 2) fs2 = feed_sel;
      if (cyc == 4) fs4 = feed_sel;
      if (cyc == 45) lr45 = last_round;
      if (cyc == 47) lr47 = last_round;
      if (out_valid) begin
        first_ov = cyc;
        break;
      end
      tick();
    end
    nchk++;
    if (smp_cyc.size() != 24) begin
      nerr++;
      $display("FAIL nominal_count: got %0d samples expected 24", smp_cyc.size());
    end
    for (int k = 0; k < smp_cyc.size() && k < 24; k++) begin
      nchk++;
      if (smp_cyc[k] != 1 + 2 * k || smp_idx[k] != k || smp_fs[k] !== (k != 0)) begin
        nerr++;
        $display("FAIL nominal_round%0d: cyc %0d idx %0d feed %0b expected cyc %0d idx %0d feed %0b",
                 k, smp_cyc[k], smp_idx[k], smp_fs[k], 1 + 2 * k, k, (k != 0));
      end
    end
    nchk++;
    if (fs2 !== 1'b0 || fs4 !== 1'b1) begin
      nerr++;
      $display("FAIL nominal_feed_wait: cyc2 %0b cyc4 %0b expected 0 1", fs2, fs4);
    end
    nchk++;
    if (lr45 !== 1'b0 || lr47 !== 1'b1) begin
      nerr++;
      $display("FAIL nominal_last_round: cyc45 %0b cyc47 %0b expected 0 1", lr45, lr47);
    end
    nchk++;
    if (first_ov != 49) begin
      nerr++;
      $display("FAIL nominal_out_valid: got cycle %0d expected 49", first_ov);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      nchk++;
      if (out_valid !== 1'b1 || round_idx !== 5'd23 || busy !== 1'b1 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL hold_%0d: ov %0b idx %0d busy %0b in_ready %0b expected 1 23 1 0",
                 i, out_valid, round_idx, busy, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    out_ready = 1'b0;
    nchk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL b2b_idle: in_ready %0b busy %0b ov %0b idx %0d expected 1 0 0 0",
               in_ready, busy, out_valid, round_idx);
    end
    tick();
    in_valid = 1'b0;
    nchk++;
    if (round_sample !== 1'b1 || feed_sel !== 1'b0 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL b2b_accept: sample %0b feed %0b idx %0d expected 1 0 0",
               round_sample, feed_sel, round_idx);
    end
  endtask

  task automatic test_midrun_reset();
    int n = 0;
    while (round_idx != 5'd7 && n < 40) begin
      tick();
      n++;
    end
    nchk++;
    if (round_idx !== 5'd7) begin
      nerr++;
      $display("FAIL midrun_reach7: idx got %0d expected 7", round_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL midrun_reset: in_ready %0b ov %0b busy %0b idx %0d expected 1 0 0 0",
               in_ready, out_valid, busy, round_idx);
    end
  endtask

  task automatic test_spurious();
    good_force = 1'b1;
    tick();
    good_force = 1'b0;
    nchk++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL spur_idle: in_ready %0b busy %0b idx %0d expected 1 0 0",
               in_ready, busy, round_idx);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    good_force = 1'b1;
    tick();
    good_force = 1'b0;
    nchk++;
    if (round_idx !== 5'd0 || busy !== 1'b1 || round_sample !== 1'b0) begin
      nerr++;
      $display("FAIL spur_issue: idx %0d busy %0b sample %0b expected 0 1 0",
               round_idx, busy, round_sample);
    end
    in_valid = 1'b1;
    nchk++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL spur_in_ready_busy: got %0b expected 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    nchk++;
    if (round_idx !== 5'd1 || round_sample !== 1'b1) begin
      nerr++;
      $display("FAIL spur_advance: idx %0d sample %0b expected 1 1", round_idx, round_sample);
    end
    drain_main("spur");
  endtask

  task automatic test_watchdog();
`ifdef SHA3_SEQ_WATCHDOG_EN
    good_en = 1'b0;
    in_valid = 1'b1;
    cyc = 0;
    tick();
    in_valid = 1'b0;
    while (cyc < 9) tick();
    nchk++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      nerr++;
      $display("FAIL wd_before: busy %0b err %0b expected 1 0", busy, err);
    end
    tick();
    nchk++;
    if (err !== 1'b1 || in_ready !== 1'b1 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL wd_fire: err %0b in_ready %0b idx %0d expected 1 1 0", err, in_ready, round_idx);
    end
    repeat (3) tick();
    nchk++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL wd_sticky: err got %0b expected 1", err);
    end
    good_en = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nchk++;
    if (err !== 1'b0 || round_sample !== 1'b1) begin
      nerr++;
      $display("FAIL wd_clear: err %0b sample %0b expected 0 1", err, round_sample);
    end
    drain_main("wd");
`else
    good_en = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (200) tick();
    nchk++;
    if (busy !== 1'b1 || err !== 1'b0 || round_sample !== 1'b0 || round_idx !== 5'd0) begin
      nerr++;
      $display("FAIL nowd_wait: busy %0b err %0b sample %0b idx %0d expected 1 0 0 0",
               busy, err, round_sample, round_idx);
    end
    good_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_short();
    int nsmp = 0, smp_at = -1, first_ov = -1, lr_bad = 0;
    s_in_valid = 1'b1;
    cyc = 0;
    tick();
    s_in_valid = 1'b0;
    while (cyc <= 20) begin
      if (s_round_sample) begin
        nsmp++;
        smp_at = cyc;
      end
      if (s_out_valid) begin
        first_ov = cyc;
        break;
      end
      if (s_last_round !== 1'b1 || s_round_idx !== 5'd0) lr_bad++;
      tick();
    end
    nchk++;
    if (nsmp != 1 || smp_at != 1) begin
      nerr++;
      $display("FAIL short_sample: count %0d at %0d expected 1 at 1", nsmp, smp_at);
    end
    nchk++;
    if (first_ov != 5) begin
      nerr++;
      $display("FAIL short_out_valid: got cycle %0d expected 5", first_ov);
    end
    nchk++;
    if (lr_bad != 0) begin
      nerr++;
      $display("FAIL short_last_round: %0d busy cycles without last_round, expected 0", lr_bad);
    end
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    nchk++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL short_handoff: in_ready %0b ov %0b expected 1 0", s_in_ready, s_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_midrun_reset();
    test_spurious();
    test_watchdog();
    test_short();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
